// File: rtl/echo_pedal_if.sv
// Sample stream and status bundle between the audio interface and the echo stage.
interface echo_pedal_if #(
  parameter int unsigned WIDTH = 16
);
  logic             sample_valid;
  logic [WIDTH-1:0] sample_in;
  logic             enable;
  logic [1:0]       delay_sel;
  logic [2:0]       fb_shift;
  logic [WIDTH-1:0] sample_out;
  logic             out_valid;
  logic             ready;
  logic             overrun;

  modport master (
    output sample_valid, sample_in, enable, delay_sel, fb_shift,
    input  sample_out, out_valid, ready, overrun
  );

  modport slave (
    input  sample_valid, sample_in, enable, delay_sel, fb_shift,
    output sample_out, out_valid, ready, overrun
  );
endinterface

// File: rtl/echo_pedal.sv
// Echo/delay stage: circular sample buffer, each input mixed with a delayed,
// attenuated copy of itself; one output per accepted input, four cycles per sample.
module echo_pedal #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned WIDTH      = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  echo_pedal_if.slave  bus
);
  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam int unsigned QUARTER = 1 << (DEPTH_LOG2 - 2);

  typedef enum logic [2:0] {CLEAR, IDLE, READ, MIX, WRITE} state_t;
  state_t state;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [WIDTH-1:0]      ram_rdata, ram_wdata;
  logic [DEPTH_LOG2-1:0] ram_addr, rd_addr, wp, clr_cnt;
  logic                  ram_we, ram_re;

  logic signed [WIDTH-1:0] x_q, d_q, s_q;
  logic signed [WIDTH-1:0] d_half, d_fb, y_c, s_c;
  logic [WIDTH:0]          sum_y, sum_s;
  logic                    en_q;
  logic [2:0]              fb_q;

  function automatic logic signed [WIDTH-1:0] sat(input logic [WIDTH:0] v);
    if (v[WIDTH] == v[WIDTH-1]) begin
      sat = v[WIDTH-1:0];
    end else if (v[WIDTH]) begin
      sat = '0;
      sat[WIDTH-1] = 1'b1;
    end else begin
      sat = '1;
      sat[WIDTH-1] = 1'b0;
    end
  endfunction

  // delay_sel=3 yields a full-depth delay, which truncates to wp (oldest sample)
  always_comb begin
    rd_addr   = wp - DEPTH_LOG2'((32'(bus.delay_sel) + 32'd1) * QUARTER);
    ram_we    = Reset && (state == CLEAR || state == WRITE);
    ram_re    = Reset && (state == IDLE) && bus.sample_valid;
    ram_addr  = (state == CLEAR) ? clr_cnt : ((state == IDLE) ? rd_addr : wp);
    ram_wdata = (state == CLEAR) ? '0 : s_q;
  end

  always_ff @(posedge Clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end else if (ram_re) begin
      ram_rdata <= mem[ram_addr];
    end
  end

  always_comb begin
    d_half = d_q >>> 1;
    d_fb   = d_q >>> fb_q;
    sum_y  = {x_q[WIDTH-1], x_q} + {d_half[WIDTH-1], d_half};
    sum_s  = {x_q[WIDTH-1], x_q} + {d_fb[WIDTH-1], d_fb};
    y_c    = sat(sum_y);
    s_c    = (fb_q == 3'd0) ? x_q : sat(sum_s);
    if (!en_q) begin
      y_c = x_q;
      s_c = x_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state          <= CLEAR;
      clr_cnt        <= '0;
      wp             <= '0;
      bus.sample_out <= '0;
      bus.out_valid  <= 1'b0;
      bus.ready      <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      if (bus.sample_valid && state != IDLE) begin
        bus.overrun <= 1'b1;
      end
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + DEPTH_LOG2'(1);
          if (clr_cnt == DEPTH_LOG2'(DEPTH - 1)) begin
            state     <= IDLE;
            bus.ready <= 1'b1;
          end
        end
        IDLE: begin
          if (bus.sample_valid) begin
            x_q       <= bus.sample_in;
            en_q      <= bus.enable;
            fb_q      <= bus.fb_shift;
            bus.ready <= 1'b0;
            state     <= READ;
          end
        end
        READ: begin
          d_q   <= ram_rdata;
          state <= MIX;
        end
        // Output is registered on entry to WRITE so out_valid and sample_out
        // appear together in the same cycle as the RAM write.
        MIX: begin
          s_q            <= s_c;
          bus.sample_out <= y_c;
          bus.out_valid  <= 1'b1;
          state          <= WRITE;
        end
        WRITE: begin
          wp        <= wp + DEPTH_LOG2'(1);
          bus.ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_echo_pedal.sv
// Bench for echo_pedal (depth 16) against an arithmetic model of the delay buffer.
module tb_echo_pedal;
  logic Clk;
  logic Reset;
  int   n_checks;
  int   n_fail;
  int   mbuf[16];
  int   mwp;

  echo_pedal_if #(.WIDTH(16)) bus ();

  echo_pedal #(.DEPTH_LOG2(4), .WIDTH(16)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic void model_clear();
    foreach (mbuf[i]) mbuf[i] = 0;
    mwp = 0;
  endfunction

  function automatic int model_step(input int x, input bit en, input int sel, input int fb);
    int dly, d, y, s;
    dly = (sel + 1) * 4;
    d   = mbuf[((mwp - dly) % 16 + 16) % 16];
    y   = en ? sat16(x + (d >>> 1)) : x;
    s   = (en && fb != 0) ? sat16(x + (d >>> fb)) : x;
    mbuf[mwp] = s;
    mwp = (mwp + 1) % 16;
    return y;
  endfunction

  // One strobe, then controls are scrambled to show they are latched at acceptance.
  task automatic send(input int x, input bit en, input int sel, input int fb,
                      output int lat, output logic [15:0] got);
    @(negedge Clk);
    bus.sample_valid = 1'b1;
    bus.sample_in    = 16'(x);
    bus.enable       = en;
    bus.delay_sel    = 2'(sel);
    bus.fb_shift     = 3'(fb);
    lat = -1;
    got = '0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge Clk);
      if (i == 1) begin
        bus.sample_valid = 1'b0;
        bus.sample_in    = 16'($urandom);
        bus.enable       = ~en;
        bus.delay_sel    = 2'($urandom);
        bus.fb_shift     = 3'($urandom);
      end
      if (bus.out_valid && lat < 0) begin
        lat = i;
        got = bus.sample_out;
      end
    end
  endtask

  task automatic wait_ready(input bit inject, output int n, output int pulses);
    n = -1;
    pulses = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clk);
      if (inject && i == 5) bus.sample_valid = 1'b1;
      if (inject && i == 6) bus.sample_valid = 1'b0;
      if (bus.out_valid) pulses++;
      if (bus.ready) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    int n, p;
    @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    wait_ready(1'b0, n, p);
    n_checks++;
    if (n < 0) begin
      n_fail++;
      $display("FAIL reset_timeout: ready never rose, required within 40 cycles");
    end
    model_clear();
  endtask

  task automatic test_reset();
    int n, p;
    Reset = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_in = '0;
    bus.enable = 1'b1;
    bus.delay_sel = '0;
    bus.fb_shift = '0;
    repeat (2) @(negedge Clk);
    n_checks += 4;
    if (bus.sample_out !== 16'd0) begin n_fail++; $display("FAIL rst_sample_out: got %h want 0000", bus.sample_out); end
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", bus.ready); end
    if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %b want 0", bus.overrun); end
    Reset = 1'b1;
    wait_ready(1'b1, n, p);
    n_checks += 3;
    if (n !== 16) begin n_fail++; $display("FAIL clear_length: ready after %0d cycles, want 16", n); end
    if (p !== 0) begin n_fail++; $display("FAIL clear_out_valid: %0d pulses during clear, want 0", p); end
    if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL clear_overrun: got %b want 1", bus.overrun); end
    do_reset();
    n_checks++;
    if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_cleared: got %b want 0", bus.overrun); end
  endtask

  task automatic test_impulse();
    int lat, e;
    logic [15:0] got;
    for (int k = 0; k < 12; k++) begin
      send((k == 0) ? 1000 : 0, 1'b1, 0, 0, lat, got);
      e = model_step((k == 0) ? 1000 : 0, 1'b1, 0, 0);
      n_checks += 2;
      if (lat !== 3) begin n_fail++; $display("FAIL impulse_latency k=%0d: got %0d want 3", k, lat); end
      if (got !== 16'(e)) begin n_fail++; $display("FAIL impulse_value k=%0d: got %0d want %0d", k, $signed(got), e); end
    end
  endtask

  task automatic test_feedback();
    int lat, e;
    logic [15:0] got;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int k = 0; k < 22; k++) begin
        send((k == 0) ? 1024 : 0, 1'b1, pass * 3, 1, lat, got);
        e = model_step((k == 0) ? 1024 : 0, 1'b1, pass * 3, 1);
        n_checks++;
        if (got !== 16'(e) || lat !== 3) begin
          n_fail++;
          $display("FAIL feedback sel=%0d k=%0d: got %0d lat %0d want %0d lat 3", pass * 3, k, $signed(got), lat, e);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int lat, e, v;
    logic [15:0] got;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      v = (k == 0 || k == 4) ? 30000 : ((k == 5 || k == 9) ? -30000 : 0);
      send(v, 1'b1, 0, 0, lat, got);
      e = model_step(v, 1'b1, 0, 0);
      n_checks++;
      if (got !== 16'(e)) begin n_fail++; $display("FAIL saturation k=%0d: got %0d want %0d", k, $signed(got), e); end
    end
  endtask

  task automatic test_bypass();
    int lat, e, v;
    logic [15:0] got;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      v = (k < 6) ? (int'($urandom_range(0, 65535)) - 32768) : 0;
      send(v, (k >= 6), 0, 0, lat, got);
      e = model_step(v, (k >= 6), 0, 0);
      n_checks++;
      if (got !== 16'(e)) begin n_fail++; $display("FAIL bypass k=%0d: got %0d want %0d", k, $signed(got), e); end
    end
  endtask

  task automatic test_random();
    int lat, e, v, sel, fb;
    bit en;
    logic [15:0] got;
    for (int k = 0; k < 40; k++) begin
      v   = int'($urandom_range(0, 65535)) - 32768;
      en  = ($urandom_range(0, 3) != 0);
      sel = int'($urandom_range(0, 3));
      fb  = int'($urandom_range(0, 7));
      send(v, en, sel, fb, lat, got);
      e = model_step(v, en, sel, fb);
      n_checks++;
      if (got !== 16'(e) || lat !== 3) begin
        n_fail++;
        $display("FAIL random k=%0d: got %0d lat %0d want %0d lat 3", k, $signed(got), lat, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses, lat, e;
    logic [15:0] got;
    do_reset();
    @(negedge Clk);
    bus.sample_valid = 1'b1;
    bus.sample_in = 16'(1234);
    bus.enable = 1'b1;
    bus.delay_sel = 2'd0;
    bus.fb_shift = 3'd0;
    pulses = 0;
    lat = -1;
    got = '0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge Clk);
      if (i == 1) bus.sample_in = 16'(-777);
      if (i == 2) bus.sample_valid = 1'b0;
      if (bus.out_valid) begin
        pulses++;
        lat = i;
        got = bus.sample_out;
      end
    end
    e = model_step(1234, 1'b1, 0, 0);
    n_checks += 4;
    if (pulses !== 1) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 1", pulses); end
    if (lat !== 3) begin n_fail++; $display("FAIL b2b_latency: got %0d want 3", lat); end
    if (got !== 16'(e)) begin n_fail++; $display("FAIL b2b_value: got %0d want %0d", $signed(got), e); end
    if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL b2b_overrun: got %b want 1", bus.overrun); end
  endtask

  task automatic test_reset_in_mix();
    int n, p, lat, e;
    logic [15:0] got;
    @(negedge Clk);
    bus.sample_valid = 1'b1;
    bus.sample_in = 16'(9999);
    bus.enable = 1'b1;
    @(negedge Clk);
    bus.sample_valid = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    p = 0;
    repeat (2) begin
      @(negedge Clk);
      if (bus.out_valid) p++;
    end
    Reset = 1'b1;
    wait_ready(1'b0, n, lat);
    model_clear();
    n_checks += 3;
    if (p + lat !== 0) begin n_fail++; $display("FAIL mix_reset_out_valid: %0d pulses want 0", p + lat); end
    if (n !== 16) begin n_fail++; $display("FAIL mix_reset_clear: ready after %0d cycles want 16", n); end
    if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL mix_reset_overrun: got %b want 0", bus.overrun); end
    for (int k = 0; k < 3; k++) begin
      send(5000 - k, 1'b1, 3, 2, lat, got);
      e = model_step(5000 - k, 1'b1, 3, 2);
      n_checks++;
      if (got !== 16'(e)) begin n_fail++; $display("FAIL post_reset k=%0d: got %0d want %0d", k, $signed(got), e); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    model_clear();
    test_reset();
    test_impulse();
    test_feedback();
    test_saturation();
    test_bypass();
    test_random();
    test_back_to_back();
    test_reset_in_mix();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/echo_pedal.md
# echo_pedal

Delay/echo effect stage for the pedal board. Consumes 16-bit signed ADC samples, one strobe per audio frame, and stores them in a circular sample buffer. Emits each input mixed with a delayed, attenuated copy of itself. Sits between the audio interface's ADC sample output and the downstream pedal chain or DAC data input, and produces one output sample per accepted input sample.

## Interface
Parameters:
- DEPTH_LOG2, 12, log2 of the buffer depth in samples; must be ≥ 3.
- WIDTH, 16, sample width, two's complement.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  reset, synchronous, active-low.
- sample_valid  in  1  one-cycle strobe; sample_in is valid for the new frame.
- sample_in  in  WIDTH  signed input sample.
- enable  in  1  1 = echo active; 0 = dry passthrough.
- delay_sel  in  2  delay length select.
- fb_shift  in  3  feedback attenuation; 0 = no feedback.
- sample_out  out  WIDTH  signed output sample; held between updates.
- out_valid  out  1  one-cycle pulse when sample_out updates.
- ready  out  1  1 = an IDLE sample_valid will be accepted.
- overrun  out  1  sticky; set when a sample_valid is dropped.

## Operation
- Buffer: 2^DEPTH_LOG2 × WIDTH single-port synchronous RAM with one-cycle read latency. Write pointer wp has DEPTH_LOG2 bits and wraps modulo the depth.
- Delay D = (delay_sel+1) << (DEPTH_LOG2-2).
  - Read address = (wp − D) mod 2^DEPTH_LOG2.
  - delay_sel=3 gives read address = wp, i.e. the oldest sample.
- FSM states: CLEAR, IDLE, READ, MIX, WRITE.
  - CLEAR: entered on reset. Writes 0 to addresses 0..2^DEPTH_LOG2−1, one address per cycle, then goes to IDLE. ready=0. Any sample_valid is dropped and sets overrun.
  - IDLE: ready=1. On sample_valid, latch x=sample_in, latch delay_sel/fb_shift/enable, issue the read, then go to READ.
  - READ: capture RAM data as d; go to MIX.
  - MIX: compute both results and register them:
    - y = sat(x + (d >>> 1)).
    - s = sat(x + (d >>> fb_shift)) if fb_shift≠0, else s = x.
    - If the latched enable=0: y = x and s = x.
    - Go to WRITE.
  - WRITE: RAM[wp] ← s; wp ← wp+1; sample_out ← y; out_valid=1 for this cycle; return to IDLE.
- Arithmetic: >>> is an arithmetic shift. Sums are formed at WIDTH+1 bits. sat() clamps to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- sample_valid outside IDLE (READ/MIX/WRITE/CLEAR): the sample is dropped, overrun←1, and the in-flight operation is unaffected.
- Control inputs are sampled only on acceptance in IDLE. Changing them mid-operation has no effect on the current sample.
- overrun clears only on reset.

## Timing
- Reset values: sample_out=0, out_valid=0, ready=0, overrun=0, wp=0, state=CLEAR.
- Reset mid-operation aborts the current operation: no write, no out_valid. CLEAR restarts from address 0.
- CLEAR lasts exactly 2^DEPTH_LOG2 cycles. ready rises in the first IDLE cycle.
- Latency: sample_valid accepted in cycle n → out_valid in cycle n+3, RAM write in cycle n+3.
- Throughput: one sample per 4 cycles. Audio frame rate is far lower, so overrun indicates a fault.
- sample_valid in the same cycle as WRITE is dropped. The earliest accepted strobe is at n+4.
- sample_out is stable from the out_valid cycle until the next out_valid.

## Test plan
Benches use DEPTH_LOG2=4 (depth 16; D = 4/8/12/16).

1. Reset with Reset=0 for 2 cycles → outputs at reset values. ready=0 for 16 cycles after release, then 1. A sample_valid during CLEAR → dropped, overrun=1.
2. enable=1, delay_sel=0, fb_shift=0. Impulse 1000 then zeros, one every 8 cycles → outputs 1000, 0, 0, 0, 500, 0, … Each out_valid arrives exactly 3 cycles after its sample_valid.
3. enable=1, delay_sel=0, fb_shift=1. Impulse 1024 then zeros → outputs 1024 at k=0, 512 at k=4, 256 at k=8, 128 at k=12 (decaying echo train). Repeat with delay_sel=3: first echo at k=16, and wp wraps correctly.
4. Saturation: prime the buffer with 30000, then input 30000 at D later → sample_out=32767. With −30000 → −32768.
5. enable=0 with non-zero buffer history → sample_out equals sample_in exactly. Re-enabling shows echoes of the samples passed during bypass.
6. sample_valid on consecutive cycles → first accepted; second dropped with overrun=1, and only one out_valid. A Reset pulse issued while in MIX → no out_valid, and CLEAR reruns.
